// File: rtl/regfile_multiport.sv
// Multi-port register file with write-through bypass, priority-resolved writes
// and a one-entry-per-cycle hardware clear sweep after reset.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     ready,
  output logic                     wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              accepting;

  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic [NUM_WR-1:0] wr_live;
  logic              conflict_nxt;

  // NOTE: storage has no reset term; the clear sweep is what defines its contents.
  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
    assign ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
  end

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
    assign wa[w] = wr_addr[w*ADDR_W +: ADDR_W];
    assign wd[w] = wr_data[w*DATA_W +: DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM: state register, next-state logic, output decode.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output is given a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR: if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    clearing  = 1'b0;
    accepting = 1'b0;
    ready     = 1'b0;
    unique case (state)
      S_CLEAR: clearing = 1'b1;
      S_READY: begin
        accepting = 1'b1;
        ready     = 1'b1;
      end
      default: clearing = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clearing) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write qualification and conflict detection
  // ---------------------------------------------------------------------------
  // A write is live only in READY, and never to a hardwired-zero entry 0.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_live[w] = accepting && wr_en[w] && !((ZERO_REG != 0) && (wa[w] == '0));
    end
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (accepting && wr_en[i] && wr_en[j] && (wa[i] == wa[j])) begin
          conflict_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: ascending port loop, so the highest-index port's store lands last.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem[cnt] <= '0;
      end
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_live[w]) begin
          mem[wa[w]] <= wd[w];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path with same-edge bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_next[p] = mem[ra[p]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_live[w] && (wa[w] == ra[p])) begin
          rd_next[p] = wd[w];
        end
      end
      if ((ZERO_REG != 0) && (ra[p] == '0)) begin
        rd_next[p] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !accepting) begin
      rd_data <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data[p*DATA_W +: DATA_W] <= rd_next[p];
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a cycle model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_regfile_multiport;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     ready;
  logic                     wr_conflict;

  int checks = 0;
  int errors = 0;

  regfile_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the register file as an array, ready after DEPTH clean edges.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] exp_rd [NUM_RD];
  logic        exp_ready = 1'b0;
  logic        exp_conf  = 1'b0;
  bit          m_valid   = 1'b0;
  int          m_edges   = 0;

  always @(posedge clk) begin
    logic [31:0] nxt [DEPTH];
    int          a;
    if (rst) begin
      m_valid   = 1'b1;
      m_edges   = 0;
      exp_ready = 1'b0;
      exp_conf  = 1'b0;
      foreach (exp_rd[p]) exp_rd[p] = '0;
    end else if (m_valid) begin
      if (!exp_ready) begin
        m_edges++;
        if (m_edges == DEPTH) begin
          exp_ready = 1'b1;
          foreach (m_mem[i]) m_mem[i] = '0;
        end
        exp_conf = 1'b0;
        foreach (exp_rd[p]) exp_rd[p] = '0;
      end else begin
        nxt = m_mem;
        exp_conf = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
          a = int'(wr_addr[w*ADDR_W +: ADDR_W]);
          if (wr_en[w] && a != 0) nxt[a] = wr_data[w*DATA_W +: DATA_W];
          for (int v = w + 1; v < NUM_WR; v++)
            if (wr_en[w] && wr_en[v] && wr_addr[w*ADDR_W +: ADDR_W] == wr_addr[v*ADDR_W +: ADDR_W])
              exp_conf = 1'b1;
        end
        for (int p = 0; p < NUM_RD; p++) begin
          a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
          exp_rd[p] = (a == 0) ? 32'h0 : nxt[a];
        end
        m_mem = nxt;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ready", {31'b0, ready}, {31'b0, exp_ready});
      check("model_conflict", {31'b0, wr_conflict}, {31'b0, exp_conf});
      for (int p = 0; p < NUM_RD; p++)
        check($sformatf("model_rd%0d", p), rd_data[p*DATA_W +: DATA_W], exp_rd[p]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic set_wr(input int w, input bit en, input int a, input logic [31:0] d);
    wr_en[w] = en;
    wr_addr[w*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[w*DATA_W +: DATA_W] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    check(name, {31'b0, ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    set_rd(17, 17);
    step();

    // 1: sweep timing and cleared contents
    pulse_reset();
    check("t1_ready_after_rst", {31'b0, ready}, 32'h0);
    for (int i = 0; i < 31; i++) step();
    check("t1_ready_edge31", {31'b0, ready}, 32'h0);
    step();
    check("t1_ready_edge32", {31'b0, ready}, 32'h1);
    step();
    check("t1_read17", rd_data[0 +: 32], 32'h0);

    // 2: same-edge bypass
    set_wr(0, 1, 5, 32'hDEADBEEF);
    set_rd(5, 17);
    step();
    check("t2_bypass", rd_data[0 +: 32], 32'hDEADBEEF);
    idle_inputs();
    step();
    check("t2_stored", rd_data[0 +: 32], 32'hDEADBEEF);

    // 3: conflicting writes, highest port wins
    set_wr(0, 1, 9, 32'h11);
    set_wr(1, 1, 9, 32'h22);
    step();
    check("t3_conflict", {31'b0, wr_conflict}, 32'h1);
    idle_inputs();
    set_rd(9, 9);
    step();
    check("t3_conflict_clear", {31'b0, wr_conflict}, 32'h0);
    check("t3_winner", rd_data[32 +: 32], 32'h22);

    // 4: entry 0 hardwired
    set_wr(0, 1, 0, 32'hFFFFFFFF);
    set_rd(0, 0);
    step();
    check("t4_rd0_same", rd_data[0 +: 32], 32'h0);
    check("t4_rd1_same", rd_data[32 +: 32], 32'h0);
    idle_inputs();
    step();
    check("t4_rd0_after", rd_data[0 +: 32], 32'h0);
    check("t4_rd1_after", rd_data[32 +: 32], 32'h0);

    // distinct addresses in one edge, each read port bypassed from a different writer
    set_wr(0, 1, 7, 32'hA);
    set_wr(1, 1, 8, 32'hB);
    set_rd(7, 8);
    step();
    check("dual_bypass0", rd_data[0 +: 32], 32'hA);
    check("dual_bypass1", rd_data[32 +: 32], 32'hB);
    check("dual_no_conflict", {31'b0, wr_conflict}, 32'h0);
    idle_inputs();

    // 5: fill, reset mid-sweep, everything reads zero afterwards
    for (int i = 1; i < DEPTH; i++) begin
      set_wr(0, 1, i, 32'(i));
      step();
    end
    idle_inputs();
    set_rd(12, 31);
    step();
    check("t5_fill12", rd_data[0 +: 32], 32'd12);
    check("t5_fill31", rd_data[32 +: 32], 32'd31);
    pulse_reset();
    for (int i = 0; i < 10; i++) step();
    pulse_reset();
    for (int i = 0; i < 31; i++) step();
    check("t5_ready_edge31", {31'b0, ready}, 32'h0);
    step();
    check("t5_ready_edge32", {31'b0, ready}, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(i, DEPTH - 1 - i);
      step();
      if (i == 1 || i == 20) begin
        check($sformatf("t5_zero_rd0_%0d", i), rd_data[0 +: 32], 32'h0);
        check($sformatf("t5_zero_rd1_%0d", i), rd_data[32 +: 32], 32'h0);
      end
    end

    // 6: writes during the sweep are ignored
    pulse_reset();
    set_wr(0, 1, 3, 32'h55);
    set_wr(1, 1, 3, 32'h66);
    set_rd(3, 3);
    for (int i = 0; i < 5; i++) step();
    check("t6_no_conflict_in_clear", {31'b0, wr_conflict}, 32'h0);
    check("t6_rd_zero_in_clear", rd_data[0 +: 32], 32'h0);
    idle_inputs();
    wait_ready("t6_ready");
    step();
    check("t6_read3", rd_data[0 +: 32], 32'h0);
    check("t6_read3_p1", rd_data[32 +: 32], 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
